matrix_mult_param: RTL and testbench

//  Parametrised N x N integer matrix multiplier; next generation of the fixed 4x4 MAC-based unit.

---
 rtl/matrix_mult_param.sv | 179 +++++++++++++++++
 tb/tb_matrix_mult_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_param.sv
// N x N unsigned matrix multiplier: a single shared MAC walks row/col/k and fills matrix_C element by element.
// Optional build macro MATMUL_XOR_EN adds a mode port selecting AND/XOR (GF(2)-style) accumulation.
`timescale 1ns/1ps
module matrix_mult_param #(
  parameter int unsigned N    = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 20
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N*N*DW-1:0]     A,
  input  logic [N*N*DW-1:0]     B,
`ifdef MATMUL_XOR_EN
  input  logic                  mode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            curr_st,
  output logic [N*N*ACCW-1:0]   matrix_C
);

  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW  = N * N * DW;
  localparam int unsigned CW  = N * N * ACCW;
  localparam int unsigned PW  = 2 * DW;
  localparam int unsigned AIW = $clog2(AW);
  localparam int unsigned CIW = $clog2(CW);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     a_q, a_d;
  logic [AW-1:0]     b_q, b_d;
  logic [CW-1:0]     c_q, c_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [IW-1:0]     row_q, row_d;
  logic [IW-1:0]     col_q, col_d;
  logic [IW-1:0]     k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MATMUL_XOR_EN
  logic              mode_q, mode_d;
`endif

  logic [AIW-1:0]    a_base;
  logic [AIW-1:0]    b_base;
  logic [CIW-1:0]    c_base;
  logic [DW-1:0]     a_el;
  logic [DW-1:0]     b_el;
  logic [PW-1:0]     prod;
  logic [ACCW-1:0]   acc_next;

  // Operand fetch and one MAC step for the current (row, col, k)
  always_comb begin
    a_base = AIW'((32'(row_q) * N + 32'(k_q)) * DW);
    b_base = AIW'((32'(k_q) * N + 32'(col_q)) * DW);
    c_base = CIW'((32'(row_q) * N + 32'(col_q)) * ACCW);
    a_el   = a_q[a_base +: DW];
    b_el   = b_q[b_base +: DW];
    prod   = PW'(a_el) * PW'(b_el);
`ifdef MATMUL_XOR_EN
    acc_next = mode_q ? (acc_q ^ ACCW'(a_el & b_el)) : (acc_q + ACCW'(prod));
`else
    acc_next = acc_q + ACCW'(prod);
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MATMUL_XOR_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
`ifdef MATMUL_XOR_EN
          mode_d  = mode;
`endif
          c_d     = '0;
          acc_d   = '0;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_next;
        if (k_q == IW'(N - 1)) begin
          state_d = WRITE;
        end else begin
          k_d = IW'(k_q + 1'b1);
        end
      end
      WRITE: begin
        c_d[c_base +: ACCW] = acc_q;
        acc_d = '0;
        k_d   = '0;
        if (col_q == IW'(N - 1)) begin
          col_d = '0;
          row_d = IW'(row_q + 1'b1);
        end else begin
          col_d = IW'(col_q + 1'b1);
        end
        if ((row_q == IW'(N - 1)) && (col_q == IW'(N - 1))) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = MAC;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MATMUL_XOR_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MATMUL_XOR_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign curr_st  = state_q;
  assign matrix_C = c_q;

endmodule

// File: tb/tb_matrix_mult_param.sv
// Scoreboard bench for matrix_mult_param: stimulus pushes expected results, a negedge monitor checks each done.
`timescale 1ns/1ps
module tb_matrix_mult_param;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ACCW = 20;
  localparam int unsigned AW   = N * N * DW;
  localparam int unsigned CW   = N * N * ACCW;
  localparam int unsigned LAT  = N * N * (N + 1);

  typedef struct {
    logic [CW-1:0] c;
    int unsigned   cyc;
  } exp_t;

  logic            clock = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   A;
  logic [AW-1:0]   B;
`ifdef MATMUL_XOR_EN
  logic            mode;
`endif
  logic            busy;
  logic            done;
  logic [2:0]      curr_st;
  logic [CW-1:0]   matrix_C;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  matrix_mult_param #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clock    (clock),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
`ifdef MATMUL_XOR_EN
    .mode     (mode),
`endif
    .busy     (busy),
    .done     (done),
    .curr_st  (curr_st),
    .matrix_C (matrix_C)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: textbook row-by-column product, reduced modulo 2^ACCW
  function automatic logic [CW-1:0] model(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit m);
    logic [CW-1:0]     r;
    longint unsigned   s, x, y;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        s = 0;
        for (int k = 0; k < int'(N); k++) begin
          x = longint'(a[(i*N+k)*DW +: DW]);
          y = longint'(b[(k*N+j)*DW +: DW]);
          s = m ? (s ^ (x & y)) : (s + x * y);
        end
        r[(i*N+j)*ACCW +: ACCW] = ACCW'(s);
      end
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_mat();
    logic [AW-1:0] m;
    for (int i = 0; i < int'(N * N); i++) m[i*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  function automatic logic [CW-1:0] elem(input int idx);
    return CW'(matrix_C[idx*ACCW +: ACCW]);
  endfunction

  // Every done must match the oldest pending expectation, exactly LAT edges after acceptance
  always @(negedge clock) begin
    if (rst === 1'b0 && done === 1'b1) begin
      exp_t e;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        check("result", matrix_C, e.c);
        check("latency", CW'(cyc), CW'(e.cyc + LAT));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (busy === 1'b1 && n < 2000);
    if (busy !== 1'b0) check("idle_timeout", CW'(busy), CW'(0));
  endtask

  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit m, input bit pulses);
    exp_t e;
    wait_idle();
    A = a;
    B = b;
`ifdef MATMUL_XOR_EN
    mode = m;
`endif
    start = 1'b1;
    @(posedge clock); #1;
    e.c   = model(a, b, m);
    e.cyc = cyc;
    q.push_back(e);
    start = 1'b0;
    A = rand_mat();
    B = rand_mat();
    if (pulses) begin
      repeat (4) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      repeat (34) @(posedge clock);
      #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
  endtask

  logic [AW-1:0] a2, b2, aff, ax, bx;
  exp_t          e1, e2;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
`ifdef MATMUL_XOR_EN
    mode  = 1'b0;
`endif
    for (int r = 0; r < int'(N); r++) begin
      for (int c = 0; c < int'(N); c++) begin
        a2[(r*N+c)*DW +: DW] = DW'(r * 4 + c);
        b2[(r*N+c)*DW +: DW] = DW'(10 + r * 4 + c);
        aff[(r*N+c)*DW +: DW] = 8'hFF;
        ax[(r*N+c)*DW +: DW]  = 8'h0F;
        bx[(r*N+c)*DW +: DW]  = DW'(1 << r);
      end
    end
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", CW'(busy), CW'(0));
    check("reset_done", CW'(done), CW'(0));
    check("reset_C", matrix_C, '0);
    check("reset_state", CW'(curr_st), CW'(0));
    rst = 1'b0;

    // Directed ramp matrices, then with stray start pulses mid-run
    run_op(a2, b2, 1'b0, 1'b0);
    wait_idle();
    check("ramp_C00", elem(0), CW'(116));
    check("ramp_C33", elem(15), CW'(1046));
    run_op(a2, b2, 1'b0, 1'b1);
    wait_idle();
    check("pulse_C00", elem(0), CW'(116));
    check("pulse_C33", elem(15), CW'(1046));

    run_op(aff, aff, 1'b0, 1'b0);
    wait_idle();
    check("ff_C05", elem(5), CW'(260100));

    for (int i = 0; i < 6; i++) run_op(rand_mat(), rand_mat(), 1'b0, 1'b0);
    wait_idle();

    // start held high: second operation accepted right after DONE
    A = rand_mat();
    B = rand_mat();
    start = 1'b1;
    @(posedge clock); #1;
    e1.c = model(A, B, 1'b0);
    e1.cyc = cyc;
    e2.c = e1.c;
    e2.cyc = cyc + LAT + 2;
    q.push_back(e1);
    q.push_back(e2);
    repeat (LAT + 3) @(posedge clock);
    #1 start = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of an operation
    run_op(rand_mat(), rand_mat(), 1'b0, 1'b0);
    repeat ($urandom_range(3, 70)) @(posedge clock);
    #1 rst = 1'b1;
    void'(q.pop_back());
    #1;
    check("arst_busy", CW'(busy), CW'(0));
    check("arst_done", CW'(done), CW'(0));
    check("arst_C", matrix_C, '0);
    check("arst_state", CW'(curr_st), CW'(0));
    repeat (2) @(posedge clock);
    #1 rst = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("post_rst_state", CW'(curr_st), CW'(0));

    run_op(rand_mat(), rand_mat(), 1'b0, 1'b0);
    wait_idle();

`ifdef MATMUL_XOR_EN
    run_op(ax, bx, 1'b1, 1'b0);
    wait_idle();
    check("xor_C00", elem(0), CW'(8'h0F));
    run_op(ax, bx, 1'b0, 1'b0);
    wait_idle();
    check("arith_C00", elem(0), CW'(225));
    run_op(rand_mat(), rand_mat(), 1'b1, 1'b0);
    wait_idle();
`endif

    repeat (5) @(posedge clock);
    #1 check("queue_empty", CW'(q.size()), CW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
